dff_update_sched: RTL
=====================

Name: dff_update_sched

Overview:
- Scheduler for the team's flip-flop datapath.
- Several requesters each want to load a value into one shared D register after a programmable hold-off delay.
- The block arbitrates them round-robin, counts out the granted delay, then issues a one-cycle load strobe. It also keeps the resulting register value.
- It is the hardware equivalent of the "wait dly clocks, then update d" sequencing used around the DFF primitives.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 1, data width of the shared register.
- DW, 2, width of each per-request delay field (delay range 0..2^DW-1 cycles).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester request; held high until matching ack.
- dly_in  input  NREQ*DW  packed delays; requester i uses bits [i*DW +: DW].
- data_in  input  NREQ*WIDTH  packed data; requester i uses bits [i*WIDTH +: WIDTH].
- ack  output  NREQ  one-hot, one-cycle pulse; marks completion of the granted request.
- d_out  output  WIDTH  data being loaded; valid when d_we=1.
- d_we  output  1  one-cycle load strobe to the shared register.
- q  output  WIDTH  shared register contents (updated by this block on d_we).
- busy  output  1  high in WAIT and LOAD.
- grant_id  output  clog2(NREQ)  index of the current or last granted requester.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; ack=0, d_we=0, d_out=0, q=0, busy=0, grant_id=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Reset mid-WAIT/LOAD aborts the latched request without an ack or write; q clears.
- States: IDLE, WAIT, LOAD. State, counter, latched index, latched data and latched delay are all registered.
- Outputs decode from the registered state (no input-to-output combinational path):
  - d_we=1 only in LOAD.
  - ack[grant_id]=1 only in LOAD.
  - d_out=latched data in LOAD, 0 otherwise.
- IDLE:
  - If any req is high at an edge, grant the first requester searching last+1, last+2, ... modulo NREQ.
  - Latch its index, data and delay; set last=index.
  - Next state is LOAD if delay=0; otherwise WAIT with cnt=delay.
  - If no req, stay in IDLE.
- WAIT: cnt decrements each edge. When cnt==1 at an edge, next state is LOAD.
- LOAD:
  - Lasts exactly one cycle; q <= latched data at the closing edge.
  - Next state is always IDLE, so back-to-back grants have one IDLE cycle between them.
- Latency:
  - With the accept edge as cycle 0, d_we/ack are high during cycle dly+1; q shows the new value from cycle dly+2.
  - Minimum request spacing is dly+2 cycles.
- Inputs are sampled only at the accept edge. Changes to dly_in/data_in/req of the granted requester after acceptance are ignored.
- req dropped before ack: the transfer still completes and ack pulses anyway.
- Requester protocol: deassert req in the cycle after ack. If req is still high in the IDLE cycle after LOAD, it is treated as a new request, subject to round-robin.
- Non-granted requests stay pending; there is no ack until they are granted.
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,..,NREQ-1,0,...
- Delay is the full unsigned DW-bit value (dly=3 with DW=2 gives 3 WAIT cycles). There is no wrap issue: cnt is DW bits and is loaded only when nonzero.
- grant_id holds its value in IDLE until the next grant.

Test Plan:
- Reset then single request: rst_n low 2 cycles; req=0001, dly0=0, data0=1 → d_we and ack=0001 in cycle 1 after the accept edge; q=1 from cycle 2; busy high during cycle 1 only.
- Delay count: req=0010, dly1=3, data1=1 → busy for 4 cycles (3 WAIT + 1 LOAD); d_we in cycle 4; grant_id=1; q=1 afterwards.
- Round-robin with all four requesting continuously: req=1111, all dly=1, data_i=i[0] → ack order 0001, 0010, 0100, 1000, 0001; d_we spaced every 3 cycles; q sequence 0, 1, 0, 1.
- Held inputs ignored: accept req0 with dly0=2, data0=1, then change data0=0 and dly0=0 during WAIT → d_we occurs at cycle 3 with d_out=1.
- Reset mid-operation: accept req2 with dly=3; pull rst_n low during the 2nd WAIT cycle → no ack or d_we; q=0; the next grant goes to requester 0 if req=0101.
- Randomized soak: 20 iterations with random dly (0..3), data and req masks → scoreboard checks each ack is one-hot to a pending requester, d_we count equals ack count, q equals the last d_out, and no requester is skipped by the round-robin.

Source files
------------

// File: rtl/dff_update_sched_if.sv
// Request/load bus of the shared-D-register update scheduler.
// The master drives the requests; the slave (scheduler) drives grant, load and register outputs.
interface dff_update_sched_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 1,
   parameter int DW    = 2
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: a requester holds req[i] high until ack[i] pulses for one cycle,
   // then drops it in the following cycle; dly/data are sampled only at the accept edge.
   logic [NREQ-1:0]       req;
   logic [NREQ*DW-1:0]    dly_in;
   logic [NREQ*WIDTH-1:0] data_in;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      d_out;
   logic                  d_we;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic [IW-1:0]         grant_id;
   logic [1:0]            fsm_state;

   modport master (
      output req, dly_in, data_in,
      input  ack, d_out, d_we, q, busy, grant_id, fsm_state
   );

   modport slave (
      input  req, dly_in, data_in,
      output ack, d_out, d_we, q, busy, grant_id, fsm_state
   );
endinterface

// File: rtl/dff_update_sched.sv
// Round-robin scheduler: grants one requester, waits its hold-off delay,
// then strobes a one-cycle load into the shared register it keeps in q.
module dff_update_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 1,
   parameter int DW    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   dff_update_sched_if.slave  bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, LOAD = 2'd2} state_t;

   state_t           state, state_n;
   logic [DW-1:0]    cnt;
   logic [IW-1:0]    gid, last;
   logic [WIDTH-1:0] data_l, q_r;

   logic             found;
   logic [IW-1:0]    pick, idx;
   logic [DW-1:0]    pick_dly;
   logic [WIDTH-1:0] pick_data;

   // Search last+1, last+2, ... wrapping at NREQ-1 so the last winner has lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = last;
      idx   = last;
      for (int k = 0; k < NREQ; k++) begin
         idx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      pick_dly  = '0;
      pick_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == IW'(i)) begin
            pick_dly  = bus.dly_in[i*DW +: DW];
            pick_data = bus.data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      bus.ack   = '0;
      bus.d_we  = 1'b0;
      bus.d_out = '0;
      bus.busy  = 1'b0;
      case (state)
         IDLE: if (found) state_n = (pick_dly == '0) ? LOAD : WAIT;
         WAIT: begin
            bus.busy = 1'b1;
            if (cnt == DW'(1)) state_n = LOAD;
         end
         LOAD: begin
            bus.busy  = 1'b1;
            bus.d_we  = 1'b1;
            bus.ack   = NREQ'(1) << gid;
            bus.d_out = data_l;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         gid    <= '0;
         last   <= IW'(NREQ - 1);
         data_l <= '0;
         q_r    <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               gid    <= pick;
               last   <= pick;
               data_l <= pick_data;
               if (pick_dly != '0) cnt <= pick_dly;
            end
            WAIT:    cnt <= cnt - 1'b1;
            LOAD:    q_r <= data_l;
            default: ;
         endcase
      end
   end

   assign bus.q         = q_r;
   assign bus.grant_id  = gid;
   assign bus.fsm_state = state;
endmodule
